cim_result_reader: RTL and testbench
====================================

# cim_result_reader

Read-side companion to the 8-MAC compute-in-SRAM array. It snapshots either the 19-bit adder-tree dot-product sum or one MAC's 16-bit product, then streams the snapshot out as bytes over an 8-bit valid/ready channel toward the output pins. The array's load path writes operands in; this block reads results out.

## Interface
- `SUM_W`, 19: width of the adder-tree sum input.
- `PROD_W`, 16: width of each MAC product.
- `N_MAC`, 8: number of MACs. Valid selects are 0..N_MAC-1 plus N_MAC.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: read request strobe.
- `req_ready` out 1: block can accept a request.
- `req_sel` in 4: target select. 0..7 picks MAC product i; 8 picks the adder-tree sum; 9..15 are invalid.
- `sum_in` in SUM_W: live adder-tree sum.
- `prod_in` in N_MAC*PROD_W: flattened products; MAC i occupies `[PROD_W*i+PROD_W-1 : PROD_W*i]`.
- `out_data` out 8: current result byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_last` out 1: current byte is the final byte of the result.
- `busy` out 1: a transfer is in progress.
- `err` out 1: one-cycle pulse on an invalid select.

## Operation
- FSM has two states, IDLE and SEND.
- `req_ready` = (state == IDLE) && !rst.
- **Request accept.** In IDLE, `req_valid && req_ready` with a valid select does the following on that edge:
  - Loads a 24-bit shift register with the zero-extended snapshot.
    - Sum: `{5'b0, sum_in}`, byte count 3.
    - Product: `{8'b0, prod_in[sel]}`, byte count 2.
  - Goes to SEND.
- **Invalid select** (9..15) with `req_valid` in IDLE:
  - No capture; state stays IDLE.
  - `err` = 1 for exactly the next cycle.
- **SEND state:**
  - `out_valid` = 1.
  - `out_data` = shift register [7:0]. Byte order is little-endian, LSB first.
  - `out_last` = 1 when remaining count == 1.
  - On each `out_valid && out_ready`: shift right by 8 and decrement the count.
  - The handshake on the last byte returns the FSM to IDLE.
- **Backpressure.** While `out_ready` = 0, `out_data`, `out_valid` and `out_last` hold stable. `out_valid` never drops before its handshake.
- **Snapshot isolation.** Changes on `sum_in`/`prod_in` after the capture edge do not affect the transfer in flight.
- `req_valid` while busy is ignored. It is not queued and does not raise `err`.
- `busy` = (state == SEND).
- All outputs are registered or decoded from registered state. No combinational path exists from `out_ready` or `req_valid` to any output.
- `out_data` and `out_last` are 0 whenever `out_valid` = 0.

## Timing
- **Reset.** `rst` high at an edge forces:
  - state = IDLE, count = 0, shift register = 0;
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `err` = 0, `busy` = 0;
  - `req_ready` = 0 while `rst` is high and 1 from the first cycle after release.
- **Reset mid-transfer** aborts it. Remaining bytes are dropped and `out_valid` is low in the cycle after the reset edge.
- **Latency.** A request accepted at edge N gives a first byte with `out_valid` = 1 in cycle N+1.
  - With `out_ready` held at 1, a sum takes 3 consecutive cycles and a product takes 2.
- **Turnaround.** After the final handshake at edge M:
  - `out_valid` = 0 and `req_ready` = 1 in cycle M+1;
  - the next accept is at edge M+1 at the earliest, with its first byte in cycle M+2 (one bubble).
- **`err` timing.** An invalid request at edge N gives `err` high in cycle N+1 only, even if `req_valid` stays asserted. If `req_valid` stays high with the same invalid select, `err` re-pulses every cycle.

## Test plan
- **Sum readout.** `sum_in` = 0x7F008 (8×255×255), `req_sel` = 8, `out_ready` = 1 -> bytes 0x08, 0xF0, 0x07 on 3 consecutive cycles; `out_last` only on 0x07; `req_ready` back to 1 the cycle after.
- **Product readout.** MAC 3 product = 0x1234, all others 0xFFFF, `req_sel` = 3 -> bytes 0x34, 0x12; `out_last` on 0x12; `busy` high exactly 2 cycles.
- **Backpressure plus snapshot.** Sum request, `out_ready` low for 5 cycles after the first byte, `sum_in` changed to 0 meanwhile -> 0x08 held stable for 5 cycles, then 0xF0, 0x07 are delivered unchanged.
- **Invalid select.** `req_sel` = 12 pulsed for one cycle -> `err` = 1 for one cycle, `out_valid` stays 0, `req_ready` stays 1. A request during SEND -> ignored, no `err`.
- **Reset mid-transfer.** `rst` asserted after the first product byte -> `out_valid` 0 the next cycle, `req_ready` 1 after release; a fresh sum request then returns correct bytes.
- **Back-to-back.** Two consecutive sum requests with `req_valid` held high -> exactly one idle cycle between the last byte of the first and the first byte of the second.

Source files
------------

// File: rtl/cim_result_reader.sv
// Read-side result streamer for the 8-MAC compute-in-SRAM array: snapshots the
// adder-tree sum or one MAC product and emits it LSB-first over a byte channel.
module cim_result_reader #(
  parameter int SUM_W  = 19,
  parameter int PROD_W = 16,
  parameter int N_MAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_sel,
  input  logic [SUM_W-1:0]        sum_in,
  input  logic [N_MAC*PROD_W-1:0] prod_in,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);

  localparam int SR_W  = 24;
  localparam int IDX_W = $clog2(N_MAC);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   shreg_q, shreg_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_MAC-1:0][PROD_W-1:0] prod_a;
  logic [IDX_W-1:0]             mac_idx;
  logic                         sel_sum, sel_ok;

  assign prod_a  = prod_in;
  assign mac_idx = req_sel[IDX_W-1:0];
  assign sel_sum = (req_sel == 4'(N_MAC));
  assign sel_ok  = (req_sel <= 4'(N_MAC));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (sel_ok) begin
            shreg_d = sel_sum ? SR_W'(sum_in) : SR_W'(prod_a[mac_idx]);
            cnt_d   = sel_sum ? 2'd3 : 2'd2;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        // out_valid is constant-high in SEND, so out_ready alone is the handshake
        if (out_ready) begin
          shreg_d = shreg_q >> 8;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? shreg_q[7:0] : 8'h00;
  assign out_last  = out_valid && (cnt_q == 2'd1);
  assign busy      = out_valid;
  assign req_ready = (state_q == IDLE) && !rst;
  assign err       = err_q;

endmodule

// File: tb/tb_cim_result_reader.sv
// Directed + randomized bench for cim_result_reader; expected bytes come from a
// value-level model (selected operand split into little-endian bytes).
module tb_cim_result_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_sel;
  logic [18:0]  sum_in;
  logic [127:0] prod_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         err;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] pm [8];

  cim_result_reader dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .sum_in(sum_in), .prod_in(prod_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_prod();
    for (int i = 0; i < 8; i++) prod_in[i*16 +: 16] = pm[i];
  endtask

  function automatic logic [23:0] model_val(input int sel);
    return (sel == 8) ? 24'(sum_in) : 24'(pm[sel]);
  endfunction

  function automatic logic [7:0] byte_of(input logic [23:0] v, input int k);
    return 8'((v >> (8 * k)) & 24'hFF);
  endfunction

  // Issues one read from a negedge and consumes every byte; returns at the
  // negedge of the first idle cycle after the final handshake.
  task automatic do_read(input int sel, input int stall, input bit poke, input bit scramble);
    logic [23:0] v;
    int n;
    v = model_val(sel);
    n = (sel == 8) ? 3 : 2;
    chk("pre_busy", busy, 0);
    chk("pre_ready", req_ready, 1);
    req_sel = 4'(sel); req_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (scramble) begin sum_in = '0; prod_in = '0; end
    for (int k = 0; k < n; k++) begin
      chk("valid", out_valid, 1);
      chk("data", out_data, byte_of(v, k));
      chk("last", out_last, (k == n - 1));
      chk("busy", busy, 1);
      chk("no_err", err, 0);
      chk("ready_busy", req_ready, 0);
      if (k == 0 && poke) begin req_valid = 1'b1; req_sel = 4'd12; end
      if (k == n - 1) req_valid = 1'b0;
      if (k == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, byte_of(v, 0));
          chk("hold_last", out_last, 0);
          chk("hold_err", err, 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("post_valid", out_valid, 0);
    chk("post_data", out_data, 0);
    chk("post_last", out_last, 0);
    chk("post_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_err", err, 0);
  endtask

  initial begin
    logic [18:0] v1, v2;
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; out_ready = 1'b1;
    sum_in = '0; prod_in = '0;
    for (int i = 0; i < 8; i++) pm[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", req_ready, 1);
    @(negedge clk);

    // Full-scale sum readout
    sum_in = 19'h7F008;
    do_read(8, 0, 0, 0);

    // Product readout with other MACs saturated
    for (int i = 0; i < 8; i++) pm[i] = 16'hFFFF;
    pm[3] = 16'h1234;
    pack_prod();
    do_read(3, 0, 0, 0);

    // Backpressure with live inputs wiped after capture
    sum_in = 19'h7F008;
    do_read(8, 5, 0, 1);
    for (int i = 0; i < 8; i++) pm[i] = '0;

    // Invalid select: single pulse, then held for two cycles
    req_valid = 1'b1; req_sel = 4'd12;
    @(negedge clk);
    req_valid = 1'b0;
    chk("inv_err", err, 1);
    chk("inv_valid", out_valid, 0);
    chk("inv_ready", req_ready, 1);
    @(negedge clk);
    chk("inv_err_once", err, 0);
    req_valid = 1'b1; req_sel = 4'd15;
    @(negedge clk);
    chk("inv_hold_err1", err, 1);
    @(negedge clk);
    chk("inv_hold_err2", err, 1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("inv_hold_clr", err, 0);
    chk("inv_hold_valid", out_valid, 0);

    // Request during SEND is ignored and never flags err
    pm[6] = 16'(($urandom));
    pack_prod();
    do_read(6, 2, 1, 0);
    @(negedge clk);
    chk("poke_no_queue", out_valid, 0);

    // Reset in the middle of a product transfer
    pm[5] = 16'hBEEF;
    pack_prod();
    req_valid = 1'b1; req_sel = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_b0", out_data, 8'hEF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", out_data, 0);
    chk("mid_ready_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_ready_rel", req_ready, 1);
    @(negedge clk);
    chk("mid_still_idle", out_valid, 0);
    sum_in = 19'(($urandom));
    do_read(8, 0, 0, 0);

    // Back-to-back sums with req_valid held: one bubble between results
    v1 = 19'(($urandom)); v2 = 19'(($urandom));
    sum_in = v1;
    req_valid = 1'b1; req_sel = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    sum_in = v2;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_v1_valid", out_valid, 1);
      chk("b2b_v1_data", out_data, byte_of(24'(v1), k));
      @(negedge clk);
    end
    chk("b2b_bubble", out_valid, 0);
    chk("b2b_bubble_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_v2_valid", out_valid, 1);
      chk("b2b_v2_data", out_data, byte_of(24'(v2), k));
      chk("b2b_v2_last", out_last, (k == 2));
      @(negedge clk);
    end
    chk("b2b_end", out_valid, 0);

    // Randomized reads across all valid selects
    for (int it = 0; it < 12; it++) begin
      int sel;
      sum_in = 19'(($urandom));
      for (int i = 0; i < 8; i++) pm[i] = 16'(($urandom));
      pack_prod();
      sel = int'($urandom_range(0, 8));
      do_read(sel, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
